// File: rtl/uart_rx_fsm_pkg.sv
// uart_rx_fsm_pkg: shared state encoding and frame constants for the UART receive controller
package uart_rx_fsm_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam logic [3:0] LAST_DATA_BIT = 4'd8;
  localparam int CHK_OFFSET = 2;
endpackage

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: frame-sequencing controller for the UART receiver
//   CLK, RST (async, active-low)     clock and reset
//   RX_IN, PAR_EN, prescale           serial line, parity enable, oversampling ratio (8/16/32)
//   edge_cnt, bit_cnt                 position reported by the edge/bit counter
//   strt_glitch, par_err, stp_err     checker results, valid until end of bit
//   enable, dat_samp_en               counter and sampler enables
//   strt_chk_en, deser_en,
//   par_chk_en, stp_chk_en            one-cycle strobes at the check edge of each bit
//   data_valid, par_error,
//   frame_error                       registered one-cycle frame-end pulses
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [BIT_CNT_W-1:0]  bit_cnt,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  enable,
  output logic                  dat_samp_en,
  output logic                  strt_chk_en,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  par_error,
  output logic                  frame_error
);
  state_t state, nxt;
  logic par_flag, par_nxt;
  logic eob, at_chk, done;
  // check edge sits just after the 3-sample majority window centred on HALF
  assign at_chk = edge_cnt == (prescale >> 1) + PRESCALE_W'(CHK_OFFSET);
  assign eob    = edge_cnt == prescale - PRESCALE_W'(1);
  assign done   = state == STOP && eob;
  assign enable      = state != IDLE;
  assign dat_samp_en = state != IDLE;
  assign strt_chk_en = state == START  && at_chk;
  assign deser_en    = state == DATA   && at_chk;
  assign par_chk_en  = state == PARITY && at_chk;
  assign stp_chk_en  = state == STOP   && at_chk;
  always_comb begin
    nxt     = state;
    par_nxt = par_flag;
    case (state)
      IDLE:    nxt = RX_IN ? IDLE : START;
      START: begin
        par_nxt = 1'b0;
        if (eob) nxt = strt_glitch ? IDLE : DATA;
      end
      DATA:    if (eob && bit_cnt == BIT_CNT_W'(LAST_DATA_BIT)) nxt = PAR_EN ? PARITY : STOP;
      PARITY: begin
        if (eob) begin
          nxt     = STOP;
          par_nxt = par_err;
        end
      end
      STOP:    nxt = eob ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      par_flag    <= 1'b0;
      data_valid  <= 1'b0;
      par_error   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= nxt;
      par_flag    <= par_nxt;
      data_valid  <= done && !par_flag && !stp_err;
      par_error   <= done && par_flag;
      frame_error <= done && stp_err;
    end
  end
endmodule
